// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register map, control word layout and FSM encodings for the timer
package timer_counter_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0, REG_PRESET = 2'd1, REG_COUNT = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_CNT = 2'd1, ST_INT = 2'd2;
  typedef struct packed {
    logic im;
    logic [1:0] mode;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: CPU-side load/store port and interrupt line of the timer
interface timer_counter_if;
  logic we;
  logic [3:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic irq;
  modport master(output we, addr, wdata, input rdata, irq);
  modport slave(input we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot/auto-reload modes and maskable irq
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] PRESET_INIT = '0
) (
  input logic clk,
  input logic reset,
  timer_counter_if.slave bus
);
  ctrl_t ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [1:0] state;
  logic irq_pend;
  logic [1:0] sel;
  logic unused_addr;
  assign sel = bus.addr[3:2];
  assign unused_addr = ^bus.addr[1:0];
  assign bus.irq = irq_pend & ctrl.im;
  always_comb
    bus.rdata = sel == REG_CTRL ? {28'b0, ctrl} :
                sel == REG_PRESET ? preset :
                sel == REG_COUNT ? count : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl <= '0;
      preset <= PRESET_INIT;
      count <= '0;
      state <= ST_IDLE;
      irq_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (ctrl.en) begin
            count <= preset;
            state <= ST_CNT;
          end
        ST_CNT:
          if (!ctrl.en) state <= ST_IDLE;
          else if (count == '0) begin
            state <= ST_INT;
            irq_pend <= 1'b1;
          end else count <= count - CNT_W'(1);
        ST_INT: begin
          state <= ST_IDLE;
          if (ctrl.mode == MODE_RELOAD) irq_pend <= 1'b0;
          else ctrl.en <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // bus writes come last so they override same-cycle FSM updates
      if (bus.we && sel == REG_CTRL) begin
        ctrl <= ctrl_t'(bus.wdata[3:0]);
        irq_pend <= 1'b0;
      end
      if (bus.we && sel == REG_PRESET) begin
        preset <= bus.wdata;
        irq_pend <= 1'b0;
      end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed vector table plus hand sequences for timer_counter
module tb_timer_counter;
  logic clk;
  logic reset;
  int applied;
  int errs;
  timer_counter_if bus();
  timer_counter #(.CNT_W(32), .PRESET_INIT(32'hA5)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic we;
    logic [3:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic irq;
  } vec_t;
  vec_t vt[$];
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  function automatic vec_t mk(logic we, logic [3:0] a, logic [31:0] d, logic [31:0] r, logic i);
    vec_t v;
    v.we = we;
    v.addr = a;
    v.wdata = d;
    v.rdata = r;
    v.irq = i;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask
  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask
  task automatic wait_count(input string name, input logic [31:0] exp);
    int n = 0;
    bus.addr = 4'h8;
    #1;
    while (bus.rdata !== exp && n < 20) begin
      step();
      n++;
    end
    chk(name, bus.rdata, exp);
  endtask
  task automatic wait_irq(input string name);
    int n = 0;
    while (bus.irq !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(name, {31'b0, bus.irq}, 32'd1);
  endtask
  initial begin
    applied = 0;
    errs = 0;
    reset = 1'b1;
    bus.we = 1'b0;
    bus.addr = 4'h0;
    bus.wdata = '0;
    // one-shot, PRESET = 5
    vt.push_back(mk(1, 4'h4, 32'h5, 32'hA5, 0));
    vt.push_back(mk(1, 4'h0, 32'h9, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h5, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h4, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h3, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h2, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h1, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 32'h9, 1));
    vt.push_back(mk(0, 4'h0, 0, 32'h8, 1));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 1));
    vt.push_back(mk(1, 4'h4, 32'h3, 32'h5, 1));
    vt.push_back(mk(0, 4'h4, 0, 32'h3, 0));
    // auto-reload, PRESET = 2
    vt.push_back(mk(1, 4'h4, 32'h2, 32'h3, 0));
    vt.push_back(mk(1, 4'h0, 32'hB, 32'h8, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h2, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h1, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 1));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h2, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h1, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 1));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 32'hB, 0));
    vt.push_back(mk(1, 4'h0, 32'h0, 32'hB, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    // masked interrupt with PRESET = 0, then ignored write to 0xC
    vt.push_back(mk(1, 4'h4, 32'h0, 32'h2, 0));
    vt.push_back(mk(1, 4'h0, 32'h1, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 32'h1, 0));
    vt.push_back(mk(0, 4'h0, 0, 32'h0, 0));
    vt.push_back(mk(1, 4'hC, 32'hFFFF_FFFF, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h4, 0, 32'h0, 0));
    vt.push_back(mk(0, 4'h8, 0, 32'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (vt[i]) begin
      bus.we = vt[i].we;
      bus.addr = vt[i].addr;
      bus.wdata = vt[i].wdata;
      #2;
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].rdata);
      chk($sformatf("vec%0d_irq", i), {31'b0, bus.irq}, {31'b0, vt[i].irq});
      step();
    end
    bus.we = 1'b0;
    // MODE = 10 must behave as one-shot
    wr(4'h4, 32'h0);
    wr(4'h0, 32'hD);
    step();
    step();
    chk("mode2_irq", {31'b0, bus.irq}, 32'd1);
    step();
    rd("mode2_en_clear", 4'h0, 32'hC);
    chk("mode2_sticky", {31'b0, bus.irq}, 32'd1);
    // enable drop, illegal COUNT write, re-enable reload, PRESET write while counting
    wr(4'h4, 32'h6);
    chk("preset_wr_clears_irq", {31'b0, bus.irq}, 32'd0);
    wr(4'h0, 32'h9);
    wait_count("reach4", 32'h4);
    wr(4'h0, 32'h8);
    rd("drop_cnt3", 4'h8, 32'h3);
    step();
    rd("drop_hold3", 4'h8, 32'h3);
    wr(4'h8, 32'hFFFF);
    rd("illegal_count_wr", 4'h8, 32'h3);
    rd("ctrl_en0", 4'h0, 32'h8);
    wr(4'h0, 32'h9);
    step();
    rd("reenable_reload", 4'h8, 32'h6);
    wr(4'h4, 32'h9);
    rd("preset_during_cnt", 4'h8, 32'h5);
    rd("preset_readback", 4'h4, 32'h9);
    wait_count("reach3", 32'h3);
    // asynchronous reset mid-count, away from the clock edge
    #1;
    reset = 1'b1;
    rd("rst_count", 4'h8, 32'h0);
    rd("rst_ctrl", 4'h0, 32'h0);
    rd("rst_preset", 4'h4, 32'hA5);
    chk("rst_irq", {31'b0, bus.irq}, 32'd0);
    #1;
    reset = 1'b0;
    step();
    // CTRL write in the one-shot INT cycle wins over the EN clear
    wr(4'h4, 32'h2);
    wr(4'h0, 32'h9);
    wait_irq("simul_reach_int");
    wr(4'h0, 32'h9);
    rd("simul_en_kept", 4'h0, 32'h9);
    chk("simul_pend_clr", {31'b0, bus.irq}, 32'd0);
    step();
    rd("simul_reload", 4'h8, 32'h2);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule
